// File: rtl/mem_line_responder.sv
// ---------------------------------------------------------------------------
// mem_line_responder
//
// Line-granular memory responder behind a cache arbiter. A request names a
// line by byte address. After a fixed access latency the responder either
// streams the line out as fill beats (req_we=0) or collects the writeback
// beats (req_we=1) and then pulses wr_done. The backing store is read
// asynchronously and written on clk.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous reset, active-high (store contents survive)
//   req_valid    line request valid
//   req_ready    responder accepts a request (high only while idle)
//   req_addr     byte address of the requested line
//   req_we       1 = line writeback, 0 = line fill
//   wdata_valid  writeback beat valid
//   wdata_ready  responder accepts a writeback beat
//   wdata        writeback beat data
//   rdata_valid  fill beat valid
//   rdata_ready  arbiter accepts a fill beat
//   rdata        fill beat data
//   rdata_last   marks the final fill beat
//   wr_done      one-cycle writeback-complete pulse
// ---------------------------------------------------------------------------
module mem_line_responder #(
    parameter int DATA_W      = 32,
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_we,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              wr_done
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = $clog2(LINE_WORDS);
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [BW-1:0] BEAT_LAST = BW'(LINE_WORDS - 1);
    localparam logic [AW-1:0] LINE_MASK = AW'(LINE_WORDS - 1);
    localparam logic [LW-1:0] LAT_INIT  = LW'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        RD_BURST = 3'd2,
        WR_BURST = 3'd3,
        WR_ACK   = 3'd4
    } state_t;

    state_t            state_r;
    logic              we_r;
    logic [AW-1:0]     base_r;
    logic [LW-1:0]     lat_cnt_r;
    logic [BW-1:0]     beat_r;
    logic              req_ready_r;
    logic              wdata_ready_r;
    logic              rdata_valid_r;
    logic              rdata_last_r;
    logic              wr_done_r;

    logic [DATA_W-1:0] mem_r [DEPTH_WORDS];
    logic [AW-1:0]     mem_addr_s;
    logic [AW-1:0]     req_base_s;
    logic              wr_beat_s;
    logic              unused_addr_s;

    // Word address with the in-line offset cleared; upper bits beyond the
    // store size are dropped so out-of-range addresses wrap.
    assign req_base_s = req_addr[AW+1:2] & ~LINE_MASK;

    // base is line-aligned, so OR-ing the beat in can never cross a line.
    assign mem_addr_s = base_r | AW'(beat_r);
    assign wr_beat_s  = (state_r == WR_BURST) && wdata_valid;

    // Byte-offset bits and bits above the store size do not select a word.
    assign unused_addr_s = ^{req_addr[1:0], req_addr >> (AW + 2)};

    assign req_ready   = req_ready_r;
    assign wdata_ready = wdata_ready_r;
    assign rdata_valid = rdata_valid_r;
    assign rdata_last  = rdata_last_r;
    assign wr_done     = wr_done_r;
    assign rdata       = mem_r[mem_addr_s];

    // Backing store write port; no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_beat_s && !rst) begin
            mem_r[mem_addr_s] <= wdata;
        end
    end

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            we_r          <= 1'b0;
            base_r        <= '0;
            lat_cnt_r     <= '0;
            beat_r        <= '0;
            req_ready_r   <= 1'b0;
            wdata_ready_r <= 1'b0;
            rdata_valid_r <= 1'b0;
            rdata_last_r  <= 1'b0;
            wr_done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready_r) begin
                        we_r        <= req_we;
                        base_r      <= req_base_s;
                        lat_cnt_r   <= LAT_INIT;
                        beat_r      <= '0;
                        req_ready_r <= 1'b0;
                        state_r     <= WAIT;
                    end else begin
                        // Also raises req_ready the cycle after reset.
                        req_ready_r <= 1'b1;
                    end
                end
                WAIT: begin
                    if (lat_cnt_r == '0) begin
                        if (we_r) begin
                            wdata_ready_r <= 1'b1;
                            state_r       <= WR_BURST;
                        end else begin
                            rdata_valid_r <= 1'b1;
                            rdata_last_r  <= 1'b0;
                            state_r       <= RD_BURST;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LW'(1);
                    end
                end
                RD_BURST: begin
                    if (rdata_ready) begin
                        if (beat_r == BEAT_LAST) begin
                            rdata_valid_r <= 1'b0;
                            rdata_last_r  <= 1'b0;
                            req_ready_r   <= 1'b1;
                            beat_r        <= '0;
                            state_r       <= IDLE;
                        end else begin
                            beat_r       <= beat_r + BW'(1);
                            rdata_last_r <= ((beat_r + BW'(1)) == BEAT_LAST);
                        end
                    end
                end
                WR_BURST: begin
                    if (wdata_valid) begin
                        if (beat_r == BEAT_LAST) begin
                            wdata_ready_r <= 1'b0;
                            wr_done_r     <= 1'b1;
                            beat_r        <= '0;
                            state_r       <= WR_ACK;
                        end else begin
                            beat_r <= beat_r + BW'(1);
                        end
                    end
                end
                WR_ACK: begin
                    wr_done_r   <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    req_ready_r   <= 1'b0;
                    wdata_ready_r <= 1'b0;
                    rdata_valid_r <= 1'b0;
                    rdata_last_r  <= 1'b0;
                    wr_done_r     <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_line_responder.md
MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits.
REQ-002 SHALL have parameter LINE_WORDS, default 4, words per cache line; power of 2, >=2.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, backing-store size in words; power of 2, multiple of LINE_WORDS.
REQ-004 SHALL have parameter LATENCY, default 4, access latency in cycles; >=1.
REQ-005 SHALL have ports:
  clk  in  1  single clock; all logic on rising edge.
  rst  in  1  synchronous reset, active-high.
  req_valid  in  1  arbiter line request valid.
  req_ready  out  1  responder accepts a request.
  req_addr  in  32  byte address of the requested line.
  req_we  in  1  1 = line writeback, 0 = line fill.
  wdata_valid  in  1  writeback beat valid.
  wdata_ready  out  1  responder accepts a writeback beat.
  wdata  in  DATA_W  writeback beat data.
  rdata_valid  out  1  fill beat valid.
  rdata_ready  in  1  arbiter accepts a fill beat.
  rdata  out  DATA_W  fill beat data.
  rdata_last  out  1  marks the final fill beat.
  wr_done  out  1  one-cycle writeback-complete pulse.

Function
REQ-006 SHALL implement a backing store of DEPTH_WORDS x DATA_W words, read asynchronously and written on clk.
REQ-007 SHALL implement FSM states IDLE, WAIT, RD_BURST, WR_BURST, WR_ACK.
REQ-008 SHALL drive req_ready=1 only in IDLE; handshake = req_valid & req_ready.
REQ-009 On handshake SHALL latch req_we and base = ((req_addr>>2) & ~(LINE_WORDS-1)) mod DEPTH_WORDS; address bits [1:0] are ignored; out-of-range addresses wrap.
REQ-010 On handshake SHALL enter WAIT with latency counter = LATENCY-1 and beat counter = 0.
REQ-011 In WAIT SHALL decrement the counter each cycle; at counter 0, go to RD_BURST if latched req_we=0, else WR_BURST. WAIT therefore lasts exactly LATENCY cycles.
REQ-012 In RD_BURST SHALL drive rdata_valid=1 and rdata=mem[base+beat], with rdata_last=(beat==LINE_WORDS-1).
REQ-013 In RD_BURST SHALL advance beat only on rdata_valid & rdata_ready; rdata/rdata_last hold stable while rdata_ready=0 (unbounded stall).
REQ-014 The handshake on the last fill beat SHALL return the FSM to IDLE; req_ready=1 in the next cycle.
REQ-015 In WR_BURST SHALL drive wdata_ready=1; each wdata_valid & wdata_ready SHALL write wdata to mem[base+beat] and advance beat; cycles without wdata_valid stall.
REQ-016 The handshake on the last writeback beat SHALL enter WR_ACK; WR_ACK SHALL assert wr_done for exactly one cycle, then go to IDLE.
REQ-017 wdata_ready, rdata_valid, rdata_last, and wr_done SHALL be 0 outside their respective states; wdata_valid outside WR_BURST SHALL be ignored.
REQ-018 req_valid while not in IDLE SHALL be ignored; the requester holds the request until accepted.
REQ-019 Beat index SHALL be log2(LINE_WORDS) bits; base+beat never crosses a line boundary.
REQ-020 Fill-beat throughput with rdata_ready held at 1 SHALL be one beat per cycle. Back-to-back requests SHALL have at least one IDLE cycle between them.

Reset
REQ-021 While rst=1 at a clock edge SHALL force IDLE, clear both counters, and set req_ready, wdata_ready, rdata_valid, rdata_last, and wr_done to 0 in the following cycle. req_ready rises the first cycle after rst deasserts.
REQ-022 Reset mid-operation SHALL abort the burst with no response and no wr_done. Writeback beats already accepted remain written.
REQ-023 Reset SHALL NOT clear store contents.

Verification
REQ-024 Writeback then fill: write line addr 0x40 with beats 0xA0..0xA3, then read 0x40. Required: wr_done one cycle after the 4th beat; rdata = 0xA0,0xA1,0xA2,0xA3 with rdata_last on the 4th beat only.
REQ-025 Latency: fill accepted in cycle T with LATENCY=4 and rdata_ready=1. Required: rdata_valid first high in cycle T+5 and last beat in T+8; req_ready=1 in T+9.
REQ-026 Backpressure: hold rdata_ready=0 for 3 cycles on beat 1. Required: rdata and beat 1 stable throughout; no beat skipped or duplicated.
REQ-027 Alignment and wrap: read req_addr 0x4C, then byte address 4*DEPTH_WORDS+0x40. Required: both return the line at 0x40.
REQ-028 Busy and reset: pulse req_valid during WAIT, then assert rst during WR_BURST after 2 beats. Required: the busy pulse is not accepted; no wr_done is issued; beats 0-1 are written and beats 2-3 keep their old values; FSM returns to IDLE.
